io_bus_de0: RTL and testbench

Memory-mapped I/O bridge between the MIPS core's data port and `dmem` on the DE0 board. It decodes the top 256-byte window of the data address space (0xFFFF_FF00–0xFFFF_FFFF), blocks stores to that window from reaching `dmem`, and muxes I/O registers into the read path. The registers are:

- 7-segment display register
- LED register
- synchronized switch input
- debounced button status with sticky press flags

With this block in place, programs can drive `seg1`–`seg4` and `leds` and poll `buttons` and `switchs` using ordinary `lw`/`sw` instructions (e.g. `sw $t0,-256($zero)`).

---
 rtl/io_bus_de0.sv | 103 ++++++++++
 tb/tb_io_bus_de0.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_de0.sv
// io_bus_de0: memory-mapped I/O bridge (7-seg, LEDs, switches, debounced buttons) beside dmem
module io_bus_de0 #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [31:0] mem_rdata,
    output logic        dmem_we,
    output logic [31:0] rdata,
    input  logic [2:0]  buttons,
    input  logic [9:0]  switchs,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [7:0]  seg3,
    output logic [7:0]  seg4,
    output logic [9:0]  leds
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic          io_sel, wr_ok, sel_q, unused;
    logic [23:0]   seg_r;
    logic [9:0]    led_r, sw_s1, sw_s2;
    logic [2:0]    bt_s1, bt_s2, lvl, flag, tog, clr;
    logic [CW-1:0] cnt [3];
    logic [31:0]   io_rdata, io_rdata_q;

    assign io_sel  = addr[31:8] == 24'hFFFFFF;
    assign dmem_we = we & ~io_sel;
    assign wr_ok   = we & io_sel & (addr[7:4] == 4'd0);
    assign clr     = (wr_ok && addr[3:2] == 2'd3) ? wdata[10:8] : 3'd0;
    assign leds    = led_r;
    assign rdata   = sel_q ? io_rdata_q : mem_rdata;
    assign unused  = ^{addr[1:0], wdata[31:24]};

    // register file read mux; offsets beyond 0x0C inside the window read as zero
    always_comb begin
        io_rdata = (addr[7:4] != 4'd0) ? 32'd0 :
                   (addr[3:2] == 2'd0) ? {8'd0, seg_r} :
                   (addr[3:2] == 2'd1) ? {22'd0, led_r} :
                   (addr[3:2] == 2'd2) ? {22'd0, sw_s2} :
                                         {21'd0, flag, 5'd0, lvl};
    end

    // active-low hex decode; a disabled digit is fully dark including dp
    always_comb begin
        seg1 = seg_r[16] ? {~seg_r[20], HEX[seg_r[3:0]]}   : 8'hFF;
        seg2 = seg_r[17] ? {~seg_r[21], HEX[seg_r[7:4]]}   : 8'hFF;
        seg3 = seg_r[18] ? {~seg_r[22], HEX[seg_r[11:8]]}  : 8'hFF;
        seg4 = seg_r[19] ? {~seg_r[23], HEX[seg_r[15:12]]} : 8'hFF;
    end

    // a button toggles its accepted level once the counter has run out while still differing
    always_comb begin
        tog = 3'd0;
        for (int i = 0; i < 3; i++) tog[i] = (~bt_s2[i] != lvl[i]) && (cnt[i] == CMAX);
    end

    // writable registers, input synchronizers and the registered read path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r      <= '0;
            led_r      <= '0;
            sw_s1      <= '0;
            sw_s2      <= '0;
            bt_s1      <= '0;
            bt_s2      <= '0;
            sel_q      <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            if (wr_ok && addr[3:2] == 2'd0) seg_r <= wdata[23:0];
            if (wr_ok && addr[3:2] == 2'd1) led_r <= wdata[9:0];
            sw_s1      <= switchs;
            sw_s2      <= sw_s1;
            bt_s1      <= buttons;
            bt_s2      <= bt_s1;
            sel_q      <= io_sel;
            io_rdata_q <= io_rdata;
        end
    end

    // debounce counters, accepted levels and sticky press flags (a new press beats a clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
            lvl  <= '0;
            flag <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt[i]  <= ((~bt_s2[i] == lvl[i]) || tog[i]) ? '0 : cnt[i] + 1'b1;
                lvl[i]  <= lvl[i] ^ tog[i];
                flag[i] <= (flag[i] & ~clr[i]) | (tog[i] & ~lvl[i]);
            end
        end
    end
endmodule

// File: tb/tb_io_bus_de0.sv
// tb_io_bus_de0: randomized self-checking bench with a behavioural model of the I/O bridge
module tb_io_bus_de0;
    localparam int DEB = 8;

    logic        clk = 1'b0, rst_n = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic [2:0]  buttons = 3'b111;
    logic [9:0]  switchs = '0;
    logic        dmem_we;
    logic [31:0] rdata;
    logic [7:0]  seg1, seg2, seg3, seg4;
    logic [9:0]  leds;

    int checks = 0, errors = 0;

    logic [23:0] m_seg;
    logic [9:0]  m_led, m_sw1, m_sw2;
    logic [2:0]  m_b1, m_b2, m_lvl, m_flag;
    int          m_run [3];
    logic        m_sel;
    logic [31:0] m_ioq;
    logic [6:0]  hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    io_bus_de0 #(.DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we),
        .mem_rdata(mem_rdata), .dmem_we(dmem_we), .rdata(rdata),
        .buttons(buttons), .switchs(switchs),
        .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] seg_exp(input int i);
        logic [3:0] d;
        d = m_seg[4*i +: 4];
        return m_seg[16+i] ? {~m_seg[20+i], hex[d]} : 8'hFF;
    endfunction

    task automatic model_reset();
        m_seg = '0; m_led = '0; m_sw1 = '0; m_sw2 = '0;
        m_b1 = '0; m_b2 = '0; m_lvl = '0; m_flag = '0;
        m_sel = 1'b0; m_ioq = '0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic [31:0] io;
        logic        sel, ok;
        logic [2:0]  clr, rise;
        sel = addr[31:8] == 24'hFFFFFF;
        ok  = addr[7:4] == 4'd0;
        case (addr[3:2])
            2'd0:    io = {8'h0, m_seg};
            2'd1:    io = {22'h0, m_led};
            2'd2:    io = {22'h0, m_sw2};
            default: io = {21'h0, m_flag, 5'h0, m_lvl};
        endcase
        if (!ok) io = 32'd0;
        m_sel = sel;
        m_ioq = io;
        clr = 3'd0;
        if (we && sel && ok) begin
            case (addr[3:2])
                2'd0:    m_seg = wdata[23:0];
                2'd1:    m_led = wdata[9:0];
                2'd3:    clr   = wdata[10:8];
                default: ;
            endcase
        end
        rise = 3'd0;
        for (int i = 0; i < 3; i++) begin
            if ((~m_b2[i]) != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_lvl[i] = ~m_lvl[i];
                    rise[i]  = m_lvl[i];
                    m_run[i] = 0;
                end
            end else m_run[i] = 0;
        end
        m_flag = (m_flag & ~clr) | rise;
        m_b2 = m_b1;  m_b1 = buttons;
        m_sw2 = m_sw1; m_sw1 = switchs;
    endtask

    task automatic check_out();
        chk("seg1", {24'h0, seg1}, {24'h0, seg_exp(0)});
        chk("seg2", {24'h0, seg2}, {24'h0, seg_exp(1)});
        chk("seg3", {24'h0, seg3}, {24'h0, seg_exp(2)});
        chk("seg4", {24'h0, seg4}, {24'h0, seg_exp(3)});
        chk("leds", {22'h0, leds}, {22'h0, m_led});
        chk("rdata", rdata, m_sel ? m_ioq : mem_rdata);
    endtask

    task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [31:0] m);
        @(negedge clk);
        addr = a; we = w; wdata = d; mem_rdata = m;
        #1 chk("dmem_we", {31'h0, dmem_we}, {31'h0, w & (a[31:8] != 24'hFFFFFF)});
        @(posedge clk);
        model_step();
        #1 check_out();
    endtask

    task automatic lw(input logic [31:0] a);
        cyc(a, 1'b0, $urandom, $urandom);
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_seg1", {24'h0, seg1}, 32'hFF);
        chk("rst_seg2", {24'h0, seg2}, 32'hFF);
        chk("rst_seg3", {24'h0, seg3}, 32'hFF);
        chk("rst_seg4", {24'h0, seg4}, 32'hFF);
        chk("rst_leds", {22'h0, leds}, 32'h0);
        chk("rst_rdata", rdata, mem_rdata);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_cycles(input int n);
        logic [31:0] a;
        int          r;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(11) == 0) buttons[$urandom_range(2)] ^= 1'b1;
            if ($urandom_range(15) == 0) switchs = 10'($urandom);
            r = int'($urandom_range(7));
            if (r < 4) a = 32'hFFFFFF00 | (r << 2);
            else if (r == 4) a = {24'hFFFFFF, 4'($urandom_range(15, 1)), 4'($urandom)};
            else a = $urandom;
            cyc(a, $urandom_range(3) == 0, $urandom, $urandom);
        end
    endtask

    initial begin
        model_reset();
        mem_rdata = 32'h12345678;
        #3 reset_now();
        repeat (3) lw(32'h0);

        cyc(32'hFFFFFF00, 1'b1, 32'h003F1A2B, $urandom);
        chk("seg_b", {24'h0, seg1}, 32'h03);
        chk("seg_2", {24'h0, seg2}, 32'h24);
        chk("seg_A", {24'h0, seg3}, 32'h88);
        chk("seg_1", {24'h0, seg4}, 32'hF9);

        cyc(32'h00000100, 1'b1, 32'h0, $urandom);
        chk("seg_kept", {24'h0, seg1}, 32'h03);
        cyc(32'hFFFFFF04, 1'b1, 32'h000002A5, $urandom);
        cyc(32'hFFFFFF04, 1'b0, 32'h0, 32'hDEADBEEF);
        chk("led_read", rdata, 32'h000002A5);

        buttons = 3'b101;
        repeat (5) lw(32'hFFFFFF0C);
        buttons = 3'b111;
        repeat (15) lw(32'hFFFFFF0C);
        chk("glitch", rdata, 32'h0);

        buttons = 3'b101;
        for (int k = 1; k <= 20; k++) begin
            lw(32'hFFFFFF0C);
            if (k == 10) chk("press_early", rdata, 32'h0);
            if (k == 11) chk("press_edge", rdata, 32'h202);
        end
        buttons = 3'b111;
        repeat (15) lw(32'hFFFFFF0C);
        chk("release", rdata, 32'h200);

        cyc(32'hFFFFFF0C, 1'b1, 32'h200, $urandom);
        lw(32'hFFFFFF0C);
        chk("w1c", rdata, 32'h0);
        buttons = 3'b101;
        repeat (9) lw(32'hFFFFFF0C);
        cyc(32'hFFFFFF0C, 1'b1, 32'h200, $urandom);
        lw(32'hFFFFFF0C);
        chk("set_wins", rdata, 32'h202);
        buttons = 3'b111;
        repeat (15) lw(32'hFFFFFF0C);

        switchs = 10'h155;
        lw(32'hFFFFFF08);
        lw(32'hFFFFFF08);
        chk("sw_sync", rdata, 32'h0);
        lw(32'hFFFFFF08);
        chk("sw_read", rdata, 32'h155);

        rand_cycles(3000);
        #2 reset_now();
        rand_cycles(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
